// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, oversampled majority-vote bit
// decisions, parity/framing/break detection and a one-deep holding register.
module uart_rx_param #(
  parameter int CLOCK_RATE  = 12000000,
  parameter int BAUD_RATE   = 9600,
  parameter int OVERSAMPLE  = 16,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic                 rxEn,
  input  logic                 rxIn,
  input  logic                 rxAck,
  output logic                 rxBusy,
  output logic                 rxDone,
  output logic                 rxValid,
  output logic [DATA_BITS-1:0] rxOut,
  output logic                 rxParityErr,
  output logic                 rxFrameErr,
  output logic                 rxBreak,
  output logic                 rxOverrun
);

  localparam int DIV_RAW = CLOCK_RATE / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TICK_W  = $clog2(OVERSAMPLE);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] T_S0      = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] T_S1      = TICK_W'(OVERSAMPLE / 2);
  localparam logic [TICK_W-1:0] T_DEC     = TICK_W'(OVERSAMPLE / 2 + 1);
  localparam logic [3:0]        DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]        STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
  } state_t;

  state_t                state_q;
  logic                  sync1_q, sync2_q, prev_q;
  logic [DIV_W-1:0]      div_q;
  logic [TICK_W-1:0]     tick_q;
  logic [3:0]            bit_q;
  logic [DATA_BITS-1:0]  shift_q;
  logic                  s0_q, s1_q, par_q, stop0_q;
  logic                  busy_q, done_q, valid_q, perr_q, ferr_q, brk_q, ovr_q;
  logic [DATA_BITS-1:0]  out_q;

  logic rx_s, fall_d, tick_evt_d, decide_d, maj_d, stop_first_d, ferr_d, perr_d, brk_d;

  always_comb begin
    rx_s         = sync2_q;
    fall_d       = prev_q & ~sync2_q;
    tick_evt_d   = (div_q == '0);
    decide_d     = tick_evt_d && (tick_q == T_DEC);
    maj_d        = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);
    // First stop bit is either the one being decided now or the one stored earlier.
    stop_first_d = (bit_q == '0) ? maj_d : stop0_q;
    ferr_d       = ~maj_d | ~stop_first_d;
    perr_d       = (PARITY_MODE != 0) && ((^{shift_q, par_q}) != (PARITY_MODE == 2));
    brk_d        = (shift_q == '0) && ((PARITY_MODE == 0) || !par_q) && !stop_first_d;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= S_IDLE;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      div_q   <= '0;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      s0_q    <= 1'b1;
      s1_q    <= 1'b1;
      par_q   <= 1'b0;
      stop0_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      brk_q   <= 1'b0;
      ovr_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      sync1_q <= rxIn;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      done_q  <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      brk_q   <= 1'b0;
      ovr_q   <= 1'b0;
      if (rxAck) valid_q <= 1'b0;

      if (!rxEn) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
      end else if (state_q == S_IDLE) begin
        if (fall_d) begin
          state_q <= S_START;
          busy_q  <= 1'b1;
          div_q   <= '0;
          tick_q  <= '0;
        end
      end else begin
        if (div_q == DIV_LAST) begin
          div_q  <= '0;
          tick_q <= (tick_q == TICK_LAST) ? '0 : tick_q + 1'b1;
        end else begin
          div_q <= div_q + 1'b1;
        end
        if (tick_evt_d && tick_q == T_S0) s0_q <= rx_s;
        if (tick_evt_d && tick_q == T_S1) s1_q <= rx_s;

        // States advance on the decision tick, so each state sees exactly one decision per bit.
        case (state_q)
          S_START: if (decide_d) begin
            if (maj_d) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= S_DATA;
              bit_q   <= '0;
            end
          end
          S_DATA: if (decide_d) begin
            shift_q <= {maj_d, shift_q[DATA_BITS-1:1]};
            bit_q   <= bit_q + 1'b1;
            if (bit_q == DATA_LAST) begin
              state_q <= (PARITY_MODE != 0) ? S_PARITY : S_STOP;
              bit_q   <= '0;
            end
          end
          S_PARITY: if (decide_d) begin
            par_q   <= maj_d;
            state_q <= S_STOP;
          end
          S_STOP: if (decide_d) begin
            if (bit_q == '0) stop0_q <= maj_d;
            bit_q <= bit_q + 1'b1;
            if (bit_q == STOP_LAST) begin
              done_q  <= 1'b1;
              out_q   <= shift_q;
              valid_q <= 1'b1;
              busy_q  <= 1'b0;
              perr_q  <= perr_d;
              ferr_q  <= ferr_d;
              brk_q   <= brk_d;
              ovr_q   <= valid_q & ~rxAck;
              state_q <= ferr_d ? S_WAIT_HIGH : S_IDLE;
            end
          end
          S_WAIT_HIGH: if (rx_s) state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign rxBusy      = busy_q;
  assign rxDone      = done_q;
  assign rxValid     = valid_q;
  assign rxOut       = out_q;
  assign rxParityErr = perr_q;
  assign rxFrameErr  = ferr_q;
  assign rxBreak     = brk_q;
  assign rxOverrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: four receiver configurations driven from their own
// serial lines, checked against a frame-level model of the expected outcome.
module tb_uart_rx_param;
  localparam int W = 15;  // {inst[1:0], overrun, break, frame_err, parity_err, data[8:0]}

  logic       clk = 1'b0;
  logic       rstN;
  logic [3:0] line, en, ack;
  wire  [3:0] busy, done, valid, perr, ferr, brk, ovr;
  wire  [7:0] out0, out1;
  wire  [6:0] out2;
  wire  [8:0] out3;

  always #5 clk = ~clk;

  uart_rx_param u_def (
    .clk(clk), .rstN(rstN), .rxEn(en[0]), .rxIn(line[0]), .rxAck(ack[0]),
    .rxBusy(busy[0]), .rxDone(done[0]), .rxValid(valid[0]), .rxOut(out0),
    .rxParityErr(perr[0]), .rxFrameErr(ferr[0]), .rxBreak(brk[0]), .rxOverrun(ovr[0]));

  uart_rx_param #(.BAUD_RATE(375000), .OVERSAMPLE(8)) u_a (
    .clk(clk), .rstN(rstN), .rxEn(en[1]), .rxIn(line[1]), .rxAck(ack[1]),
    .rxBusy(busy[1]), .rxDone(done[1]), .rxValid(valid[1]), .rxOut(out1),
    .rxParityErr(perr[1]), .rxFrameErr(ferr[1]), .rxBreak(brk[1]), .rxOverrun(ovr[1]));

  uart_rx_param #(.BAUD_RATE(375000), .OVERSAMPLE(8), .DATA_BITS(7), .PARITY_MODE(1)) u_b (
    .clk(clk), .rstN(rstN), .rxEn(en[2]), .rxIn(line[2]), .rxAck(ack[2]),
    .rxBusy(busy[2]), .rxDone(done[2]), .rxValid(valid[2]), .rxOut(out2),
    .rxParityErr(perr[2]), .rxFrameErr(ferr[2]), .rxBreak(brk[2]), .rxOverrun(ovr[2]));

  uart_rx_param #(.BAUD_RATE(750000), .OVERSAMPLE(4), .DATA_BITS(9), .PARITY_MODE(2),
                  .STOP_BITS(2)) u_c (
    .clk(clk), .rstN(rstN), .rxEn(en[3]), .rxIn(line[3]), .rxAck(ack[3]),
    .rxBusy(busy[3]), .rxDone(done[3]), .rxValid(valid[3]), .rxOut(out3),
    .rxParityErr(perr[3]), .rxFrameErr(ferr[3]), .rxBreak(brk[3]), .rxOverrun(ovr[3]));

  // Bit period in clocks = floor(CLOCK/(BAUD*OS)) * OS for each instance.
  int bitp  [4] = '{1248, 32, 32, 16};
  int nbits [4] = '{8, 8, 7, 9};
  int pmode [4] = '{0, 0, 1, 2};
  int nstop [4] = '{1, 1, 1, 2};

  logic       model_valid [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int stray_cnt = 0;
  logic [3:0] done_prev = '0;

  function automatic logic [8:0] out_of(input int i);
    case (i)
      0:       return {1'b0, out0};
      1:       return {1'b0, out1};
      2:       return {2'b0, out2};
      default: return out3;
    endcase
  endfunction

  // Capture every completed frame; error pulses outside rxDone or long rxDone are stray.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (done[i]) obs_q.push_back({2'(i), ovr[i], brk[i], ferr[i], perr[i], out_of(i)});
      if (!done[i] && (ovr[i] | brk[i] | ferr[i] | perr[i])) stray_cnt++;
      if (done[i] && done_prev[i]) stray_cnt++;
    end
    done_prev <= done;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame-level reference: outcome follows from bit values alone.
  task automatic expect_frame(input int i, input logic [8:0] d, input logic p,
                              input logic [1:0] stops);
    logic pe, fe, bk, ov;
    int ones;
    ones = $countones(d) + ((pmode[i] != 0) ? int'(p) : 0);
    pe = (pmode[i] == 1 && (ones % 2) != 0) || (pmode[i] == 2 && (ones % 2) != 1);
    fe = (stops[0] == 1'b0) || (nstop[i] == 2 && stops[1] == 1'b0);
    bk = (d == 9'd0) && (pmode[i] == 0 || p == 1'b0) && (stops[0] == 1'b0);
    ov = model_valid[i];
    model_valid[i] = 1'b1;
    exp_q.push_back({2'(i), ov, bk, fe, pe, d});
  endtask

  task automatic send_frame(input int i, input logic [8:0] data, input logic flip,
                            input logic [1:0] stops);
    logic [8:0]  d;
    logic        p;
    logic [15:0] bits;
    int          nb;
    d  = data & 9'((1 << nbits[i]) - 1);
    p  = (^d) ^ (pmode[i] == 2) ^ flip;
    nb = 0;
    bits = '0;
    bits[nb] = 1'b0; nb++;
    for (int k = 0; k < nbits[i]; k++) begin bits[nb] = d[k]; nb++; end
    if (pmode[i] != 0) begin bits[nb] = p; nb++; end
    for (int k = 0; k < nstop[i]; k++) begin bits[nb] = stops[k]; nb++; end
    expect_frame(i, d, p, stops);
    for (int k = 0; k < nb; k++) begin
      line[i] = bits[k];
      repeat (bitp[i]) @(negedge clk);
    end
    line[i] = 1'b1;
  endtask

  task automatic idle_bits(input int i, input int n);
    line[i] = 1'b1;
    repeat (n * bitp[i]) @(negedge clk);
  endtask

  task automatic check_frame(input string tag);
    int n;
    logic [W-1:0] o, e;
    n = 0;
    while (obs_q.size() == 0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_count"}, obs_q.size(), 1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    if (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      check(tag, o, e);
    end
    obs_q.delete();
  endtask

  task automatic do_ack(input int i, input string tag);
    check({tag, "_valid_pre"}, valid[i], model_valid[i]);
    ack[i] = 1'b1;
    @(negedge clk);
    ack[i] = 1'b0;
    model_valid[i] = 1'b0;
    check({tag, "_valid_post"}, valid[i], 0);
  endtask

  initial begin
    rstN = 1'b0;
    line = '1;
    en   = '1;
    ack  = '0;
    repeat (5) @(negedge clk);
    check("reset_flags", {busy, done, valid, perr, ferr, brk, ovr}, 0);
    check("reset_out", {out0, out1, out2, out3}, 0);
    rstN = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_after_reset", busy, 0);

    // Default configuration, 8N1.
    send_frame(0, 9'h07A, 1'b0, 2'b11);
    check_frame("def_7a");
    check("def_busy_after", busy[0], 0);
    do_ack(0, "def_ack");

    // Short low pulse: start detected, then rejected at the start-bit decision.
    line[0] = 1'b0;
    repeat (150) @(negedge clk);
    check("glitch_busy", busy[0], 1);
    repeat (150) @(negedge clk);
    line[0] = 1'b1;
    repeat (1248) @(negedge clk);
    check("glitch_idle", busy[0], 0);
    check("glitch_nodone", obs_q.size(), 0);

    // Fast 8N1: random back-to-back frames, some left unacknowledged.
    for (int k = 0; k < 8; k++) begin
      send_frame(1, 9'($urandom_range(0, 255)), 1'b0, 2'b11);
      check_frame("a_rand");
      if ($urandom_range(0, 1) == 1) do_ack(1, "a_rand_ack");
    end
    do_ack(1, "a_pre_break");

    // Line held low for 12 bit times: one break frame only.
    expect_frame(1, 9'h000, 1'b0, 2'b00);
    line[1] = 1'b0;
    repeat (12 * 32) @(negedge clk);
    check("brk_busy_low", busy[1], 0);
    idle_bits(1, 3);
    check_frame("a_break");
    send_frame(1, 9'h0C3, 1'b0, 2'b11);
    check_frame("a_after_break");
    do_ack(1, "a_post_break");

    // Overrun: two frames without acknowledge.
    send_frame(1, 9'h0B1, 1'b0, 2'b11);
    check_frame("a_b1");
    send_frame(1, 9'h05C, 1'b0, 2'b11);
    check_frame("a_5c_ovr");
    check("a_out_5c", out1, 8'h5C);

    // Abort mid-data with rxEn, then re-enable with the line still low.
    line[1] = 1'b0;
    repeat (3 * 32) @(negedge clk);
    check("abort_busy", busy[1], 1);
    en[1] = 1'b0;
    @(negedge clk);
    check("abort_idle", busy[1], 0);
    repeat (2 * 32) @(negedge clk);
    en[1] = 1'b1;
    repeat (3 * 32) @(negedge clk);
    check("reen_low_nostart", busy[1], 0);
    idle_bits(1, 2);
    check("abort_nodone", obs_q.size(), 0);
    check("abort_valid_kept", valid[1], model_valid[1]);
    check("abort_out_kept", out1, 8'h5C);
    do_ack(1, "a_post_abort");

    // 7 data bits, even parity.
    send_frame(2, 9'h035, 1'b0, 2'b11);
    check_frame("b_35_ok");
    do_ack(2, "b_ack1");
    send_frame(2, 9'h035, 1'b1, 2'b11);
    check_frame("b_35_perr");
    do_ack(2, "b_ack2");
    for (int k = 0; k < 4; k++) begin
      send_frame(2, 9'($urandom_range(0, 127)), 1'($urandom_range(0, 1)), 2'b11);
      check_frame("b_rand");
      do_ack(2, "b_rand_ack");
    end

    // 9 data bits, odd parity, two stop bits.
    for (int k = 0; k < 4; k++) begin
      send_frame(3, 9'($urandom_range(0, 511)), 1'($urandom_range(0, 1)), 2'b11);
      check_frame("c_rand");
      do_ack(3, "c_rand_ack");
    end
    send_frame(3, 9'h1A5, 1'b0, 2'b01);
    idle_bits(3, 3);
    check_frame("c_stop2_ferr");
    do_ack(3, "c_ack1");
    send_frame(3, 9'h000, 1'b0, 2'b00);
    idle_bits(3, 3);
    check_frame("c_zero_par1_nobreak");
    do_ack(3, "c_ack2");
    send_frame(3, 9'h000, 1'b1, 2'b00);
    idle_bits(3, 3);
    check_frame("c_zero_par0_break");

    // Asynchronous reset in the middle of a frame.
    send_frame(1, 9'h042, 1'b0, 2'b11);
    check_frame("a_42");
    line[1] = 1'b0;
    repeat (4 * 32) @(negedge clk);
    check("rst_busy_pre", busy[1], 1);
    rstN = 1'b0;
    #1;
    check("rst_flags", {busy, done, valid, perr, ferr, brk, ovr}, 0);
    check("rst_out", {out0, out1, out2, out3}, 0);
    line[1] = 1'b1;
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    repeat (5 * 32) @(negedge clk);
    check("rst_nodone", obs_q.size(), 0);
    check("stray_pulses", stray_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
- Parametrised successor to the fixed 8N1 receiver inside Uart8.
- Configurable data width, parity mode, stop-bit count and oversampling ratio.
- Adds majority-vote sampling, false-start rejection, parity, framing and break detection, and a one-deep holding register with overrun flag.
- Drops into the same rx slot in uart tops and loopback benches.

Parameters:
- CLOCK_RATE, 12000000: system clock frequency in Hz.
- BAUD_RATE, 9600: line baud rate.
- OVERSAMPLE, 16: samples per bit; even, ≥4.
- DATA_BITS, 8: data bits per frame, 5..9.
- PARITY_MODE, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: 1 or 2.

Ports:
- clk  in  1  system clock.
- rstN  in  1  asynchronous active-low reset.
- rxEn  in  1  receiver enable.
- rxIn  in  1  serial line, idle high, asynchronous to clk.
- rxAck  in  1  consumer acknowledge; clears rxValid.
- rxBusy  out  1  frame in progress.
- rxDone  out  1  one-cycle pulse at frame end.
- rxValid  out  1  rxOut holds unacknowledged data.
- rxOut  out  DATA_BITS  received data.
- rxParityErr  out  1  pulse with rxDone, parity mismatch.
- rxFrameErr  out  1  pulse with rxDone, stop bit sampled 0.
- rxBreak  out  1  pulse with rxDone, all-zero frame incl. stop.
- rxOverrun  out  1  pulse with rxDone when rxValid was still set.

Behaviour:
- Reset:
  - All outputs 0; rxOut = 0; state IDLE.
  - Synchroniser flops reset to 1.
  - Reset is honoured mid-frame; no rxDone is produced.
- rxIn passes through a 2-flop synchroniser (2-cycle latency); all logic uses the synchronised signal.
- Divider:
  - DIV = CLOCK_RATE / (BAUD_RATE*OVERSAMPLE), integer floor, minimum 1.
  - The tick counter runs only when state ≠ IDLE and restarts at 0 on start detection.
- Bit sampling:
  - Each bit spans OVERSAMPLE ticks.
  - Bit value = majority of the samples at ticks OS/2-1, OS/2, OS/2+1.
  - The decision is taken at tick OS/2+1.
- States:
  - IDLE: if rxEn and a synced 1→0 edge is seen, go to START and set rxBusy.
  - START: decision 1 → false start, back to IDLE with no pulses. Decision 0 → DATA.
  - DATA: DATA_BITS bits, LSB first, into a shift register. Then PARITY if PARITY_MODE ≠ 0, else STOP.
  - PARITY: even mode requires XOR(data, p) = 0; odd mode requires 1. Mismatch → parity error.
  - STOP: STOP_BITS bits, each checked at its decision tick; any 0 → framing error. The frame ends at the decision tick of the last stop bit, not at the bit end, so back-to-back frames are accepted.
  - WAIT_HIGH: entered after a framing error; the synced line must be seen high before returning to IDLE.
- Frame end (same cycle for all of the following):
  - rxDone = 1 for one cycle, and rxOut is loaded even if errors occurred.
  - rxValid is set, and rxBusy drops next cycle.
  - Error pulses are coincident with rxDone.
  - rxBreak requires data = 0, parity bit = 0 if present, and first stop bit = 0; it always comes with rxFrameErr.
- Overrun:
  - If rxValid = 1 at frame end and rxAck is not asserted that cycle, pulse rxOverrun and overwrite rxOut.
  - If rxAck and frame end coincide, no overrun; rxValid stays 1.
- rxAck while rxValid = 0 has no effect.
- rxEn low:
  - In any state, return to IDLE next cycle and clear rxBusy; no pulses.
  - rxValid and rxOut are retained.
  - A line held low at re-enable does not start a frame; a fresh falling edge is required.

Test Plan:
- Default params (DIV = 78, bit = 1248 cycles): send 0x7A 8N1 → rxDone once, rxOut = 0x7A, rxValid = 1, all error pulses 0, rxBusy low after frame.
- PARITY_MODE = 1, DATA_BITS = 7:
  - 0x35 with parity 0 → no error.
  - Same frame with parity 1 → rxParityErr with rxDone, rxOut = 0x35.
- Glitch: line low for 300 cycles, then high → no rxDone, rxBusy back to 0 within one bit time.
- Line low for 12 bit times → rxDone with rxOut = 0x00, rxFrameErr = 1, rxBreak = 1. No second frame until the line returns high and falls again.
- Overrun and acknowledge:
  - Send 0xB1 then 0x5C with no rxAck → second rxDone carries rxOverrun = 1, rxOut = 0x5C.
  - rxAck → rxValid = 0 next cycle.
- Abort and reset:
  - Drop rxEn mid-data → rxBusy = 0 next cycle, no rxDone.
  - Assert rstN low mid-frame → all outputs 0 immediately.
- Two-stop-bit frame (STOP_BITS = 2) with second stop bit 0 → rxFrameErr = 1.
